// File: rtl/hangman_pkg.sv
// hangman_pkg: shared sizes and host FSM state type for the hangman host word register
package hangman_pkg;
  localparam int WORD_LEN = 5;
  localparam int CHAR_W   = 8;
  localparam int WORD_W   = WORD_LEN * CHAR_W;
  localparam int CNT_W    = $clog2(WORD_LEN + 1);
  typedef enum logic [1:0] {ENTRY, FULL, SENT, LOCKED} host_state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: single-cycle pulse on a 0->1 transition of a synchronous level
module rise_detect (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  output logic pulse
);
  logic r_prev;
  // remember last sampled level so a held input fires only once
  always_ff @(posedge clk) r_prev <= nRst ? 1'b0 : in;
  assign pulse = in & ~r_prev;
endmodule

// File: rtl/message_reg_host.sv
// message_reg_host: captures five keypad letters into the secret word and pulses rec_ready on confirm
module message_reg_host
  import hangman_pkg::*;
(
  input  logic              clk,
  input  logic              nRst,
  input  logic              key_ready,
  input  logic [CHAR_W-1:0] setLetter,
  input  logic              toggle_state,
  input  logic              gameEnd_host,
  output logic              rec_ready,
  output logic [WORD_W-1:0] temp_word
);
  host_state_t       r_state, w_next;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic [WORD_W-1:0] w_word_next;
  logic              w_key, w_tog;
  rise_detect u_key (.clk(clk), .nRst(nRst), .in(key_ready),    .pulse(w_key));
  rise_detect u_tog (.clk(clk), .nRst(nRst), .in(toggle_state), .pulse(w_tog));
  // next state, letter shift and count; game end overrides everything
  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_word_next  = temp_word;
    if (gameEnd_host) begin
      w_next       = ENTRY;
      w_count_next = '0;
      w_word_next  = '0;
    end else begin
      case (r_state)
        ENTRY: if (w_key) begin
          w_word_next  = {temp_word[WORD_W-CHAR_W-1:0], setLetter};
          w_count_next = r_count + CNT_W'(1);
          w_next       = (r_count == CNT_W'(WORD_LEN - 1)) ? FULL : ENTRY;
        end
        FULL:    w_next = w_tog ? SENT : FULL;
        default: w_next = LOCKED;
      endcase
    end
  end
  // state, word and registered send pulse
  always_ff @(posedge clk) begin
    if (nRst) begin
      r_state   <= ENTRY;
      r_count   <= '0;
      temp_word <= '0;
      rec_ready <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count_next;
      temp_word <= w_word_next;
      rec_ready <= (w_next == SENT);
    end
  end
endmodule

// File: tb/tb_message_reg_host.sv
// tb_message_reg_host: directed and randomized checks against a queue-based word model
module tb_message_reg_host;
  logic        clk = 1'b0, nRst = 1'b1, key_ready = 1'b0, toggle_state = 1'b0, gameEnd_host = 1'b0;
  logic [7:0]  setLetter = '0;
  logic        rec_ready;
  logic [39:0] temp_word;
  int          errors = 0, checks = 0, pulses;
  logic [7:0]  q[$];
  bit          m_done, m_rr, pk, pt;

  always #5 clk = ~clk;

  message_reg_host dut (
    .clk(clk), .nRst(nRst), .key_ready(key_ready), .setLetter(setLetter),
    .toggle_state(toggle_state), .gameEnd_host(gameEnd_host),
    .rec_ready(rec_ready), .temp_word(temp_word)
  );

  function automatic logic [39:0] exp_word();
    logic [39:0] w = '0;
    foreach (q[i]) w = {w[31:0], q[i]};
    return w;
  endfunction

  task automatic tick(input bit k, t, g, r, input logic [7:0] l);
    bit ke, te;
    key_ready = k; toggle_state = t; gameEnd_host = g; nRst = r; setLetter = l;
    ke = k && !pk;
    te = t && !pt;
    m_rr = 0;
    if (r) begin
      q.delete(); m_done = 0; pk = 0; pt = 0;
    end else begin
      pk = k; pt = t;
      if (g) begin q.delete(); m_done = 0; end
      else if (!m_done && q.size() < 5) begin if (ke) q.push_back(l); end
      else if (!m_done && te) begin m_done = 1; m_rr = 1; end
    end
    @(negedge clk);
  endtask

  task automatic key(input logic [7:0] l);
    tick(1, 0, 0, 0, l);
    tick(0, 0, 0, 0, l);
  endtask

  task automatic confirm();
    pulses = 0;
    tick(0, 1, 0, 0, 8'h00);
    pulses += int'(rec_ready);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 8'h00);
      pulses += int'(rec_ready);
    end
  endtask

  task automatic clear();
    tick(0, 0, 1, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 1, "X");
    tick(1, 0, 0, 1, "X");
    checks++; if (temp_word !== 40'h0) begin errors++; $display("FAIL reset_word got %h exp 0", temp_word); end
    checks++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL reset_rr got %b exp 0", rec_ready); end
    tick(0, 0, 0, 0, "X");
    checks++; if (temp_word !== 40'h0) begin errors++; $display("FAIL reset_release_word got %h exp 0", temp_word); end
  endtask

  task automatic test_entry();
    key("F"); key("A"); key("N");
    checks++; if (temp_word !== 40'h46414E) begin errors++; $display("FAIL entry_partial got %h exp 46414e", temp_word); end
    key("T"); key("A");
    checks++; if (temp_word !== 40'h46414E5441) begin errors++; $display("FAIL entry_word got %h exp 46414e5441", temp_word); end
    checks++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL entry_rr got %b exp 0", rec_ready); end
  endtask

  task automatic test_overflow();
    key("Z");
    checks++; if (temp_word !== 40'h46414E5441) begin errors++; $display("FAIL overflow_word got %h exp 46414e5441", temp_word); end
  endtask

  task automatic test_confirm();
    confirm();
    checks++; if (pulses != 1) begin errors++; $display("FAIL confirm_pulse got %0d cycles exp 1", pulses); end
    checks++; if (temp_word !== 40'h46414E5441) begin errors++; $display("FAIL confirm_word got %h exp 46414e5441", temp_word); end
    confirm();
    checks++; if (pulses != 0) begin errors++; $display("FAIL second_toggle got %0d cycles exp 0", pulses); end
    clear();
    key("A"); key("B"); key("C");
    confirm();
    checks++; if (pulses != 0) begin errors++; $display("FAIL early_toggle got %0d cycles exp 0", pulses); end
    key("D"); key("E");
    checks++; if (temp_word !== 40'h4142434445) begin errors++; $display("FAIL entry_after_toggle got %h exp 4142434445", temp_word); end
    confirm();
    checks++; if (pulses != 1) begin errors++; $display("FAIL late_confirm got %0d cycles exp 1", pulses); end
  endtask

  task automatic test_held_key();
    clear();
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, "B");
    tick(0, 0, 0, 0, "B");
    checks++; if (temp_word !== 40'h42) begin errors++; $display("FAIL held_key got %h exp 42", temp_word); end
    key("K");
    checks++; if (temp_word !== 40'h424B) begin errors++; $display("FAIL held_then_next got %h exp 424b", temp_word); end
  endtask

  task automatic test_game_end();
    key("L"); key("M"); key("N");
    confirm();
    checks++; if (pulses != 1) begin errors++; $display("FAIL lock_pulse got %0d cycles exp 1", pulses); end
    clear();
    checks++; if (temp_word !== 40'h0) begin errors++; $display("FAIL gameend_clear got %h exp 0", temp_word); end
    key("C");
    checks++; if (temp_word !== 40'h43) begin errors++; $display("FAIL gameend_then_key got %h exp 43", temp_word); end
    tick(1, 0, 1, 0, "Q");
    tick(0, 0, 0, 0, "Q");
    checks++; if (temp_word !== 40'h0) begin errors++; $display("FAIL gameend_vs_key got %h exp 0", temp_word); end
  endtask

  task automatic test_back_to_back();
    clear();
    key("V"); key("W"); key("X"); key("Y");
    tick(1, 1, 0, 0, "Z");
    checks++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL fifth_plus_toggle_rr got %b exp 0", rec_ready); end
    tick(0, 0, 0, 0, "Z");
    checks++; if (temp_word !== 40'h565758595A) begin errors++; $display("FAIL fifth_plus_toggle_word got %h exp 565758595a", temp_word); end
  endtask

  task automatic test_random();
    clear();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0,
           0, 8'(8'h41 + $urandom_range(25, 0)));
      checks++; if (temp_word !== exp_word()) begin errors++; $display("FAIL rand_word cycle %0d got %h exp %h", i, temp_word, exp_word()); end
      checks++; if (rec_ready !== m_rr) begin errors++; $display("FAIL rand_rr cycle %0d got %b exp %b", i, rec_ready, m_rr); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_entry();
    test_overflow();
    test_confirm();
    test_held_key();
    test_game_end();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
